// File: rtl/fetch_unit.sv
// Instruction-fetch stage: writable instruction memory plus a PC that walks
// while the core is in IF, with stall, redirect, program length and halt.
module fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int IMEM_DEPTH  = 256,
  parameter int INSTR_WIDTH = 32,
  parameter int STATE_WIDTH = 3,
  parameter logic [STATE_WIDTH-1:0] IF_CODE = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STATE_WIDTH-1:0] state,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic [PC_WIDTH:0]      prog_len,
  input  logic                   load_en,
  input  logic [PC_WIDTH-1:0]    load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [PC_WIDTH:0] DEPTH = (PC_WIDTH+1)'(IMEM_DEPTH);

  logic [INSTR_WIDTH-1:0] mem [IMEM_DEPTH];

  logic                   if_cyc;
  logic                   pc_ok;
  logic                   pc_in;
  logic                   wr_in;
  logic                   do_fetch;
  logic                   do_halt;
  logic [INSTR_WIDTH-1:0] rd_data;

  assign if_cyc = (state == IF_CODE) && !stall
                  && !load_en && !redirect_valid;
  assign pc_ok  = {1'b0, program_counter} < prog_len;
  assign pc_in  = {1'b0, program_counter} < DEPTH;
  assign wr_in  = {1'b0, load_addr} < DEPTH;

  // Halt is sticky: once set, IF cycles do nothing until a redirect.
  assign do_fetch = if_cyc && !halted && pc_ok;
  assign do_halt  = if_cyc && (halted || !pc_ok);

  // Addresses beyond the memory read back as an all-zero NOP.
  assign rd_data = pc_in ? mem[program_counter[AW-1:0]]
                         : '0;

  always_ff @(posedge clk) begin
    if (load_en && wr_in)
      mem[load_addr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      program_counter <= '0;
      instruction     <= '0;
      instr_valid     <= 1'b0;
      halted          <= 1'b0;
      fetch_count     <= '0;
    end else begin
      instr_valid <= 1'b0;
      unique case (1'b1)
        redirect_valid: begin
          program_counter <= redirect_pc;
          halted          <= 1'b0;
        end
        do_fetch: begin
          instruction     <= rd_data;
          program_counter <= program_counter + 1'b1;
          instr_valid     <= 1'b1;
          if (fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
        end
        do_halt: begin
          halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a wide instance and a narrow wrapping
// instance, both checked every cycle against an abstract fetch model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] state;
  logic       stall;

  logic        rv0, le0, v0, h0;
  logic [7:0]  rpc0, la0, pc0;
  logic [8:0]  pl0;
  logic [31:0] ld0, ins0;
  logic [15:0] fc0;

  logic        rv1, le1, v1, h1;
  logic [2:0]  rpc1, la1, pc1;
  logic [3:0]  pl1;
  logic [31:0] ld1, ins1;
  logic [15:0] fc1;

  fetch_unit #(
    .PC_WIDTH(8), .IMEM_DEPTH(256), .INSTR_WIDTH(32),
    .STATE_WIDTH(3), .IF_CODE(3'd0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .state(state), .stall(stall),
    .redirect_valid(rv0), .redirect_pc(rpc0), .prog_len(pl0),
    .load_en(le0), .load_addr(la0), .load_data(ld0),
    .program_counter(pc0), .instruction(ins0),
    .instr_valid(v0), .halted(h0), .fetch_count(fc0)
  );

  fetch_unit #(
    .PC_WIDTH(3), .IMEM_DEPTH(6), .INSTR_WIDTH(32),
    .STATE_WIDTH(3), .IF_CODE(3'd0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .state(state), .stall(stall),
    .redirect_valid(rv1), .redirect_pc(rpc1), .prog_len(pl1),
    .load_en(le1), .load_addr(la1), .load_data(ld1),
    .program_counter(pc1), .instruction(ins1),
    .instr_valid(v1), .halted(h1), .fetch_count(fc1)
  );

  typedef struct {
    int          pc;
    logic [31:0] ins;
    bit          v;
    bit          h;
    int          cnt;
  } ms_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] ref0 [256];
  logic [31:0] ref1 [6];
  ms_t s0, s1;

  function automatic ms_t mstep(ms_t s, bit ifs, bit rv, int rpc,
                                int len, int w, logic [31:0] rd);
    ms_t n = s;
    n.v = 1'b0;
    if (rv) begin
      n.pc = rpc;
      n.h  = 1'b0;
    end else if (ifs) begin
      if (s.h || s.pc >= len) begin
        n.h = 1'b1;
      end else begin
        n.ins = rd;
        n.pc  = (s.pc + 1) % (1 << w);
        n.v   = 1'b1;
        if (s.cnt < 65535) n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  function automatic ms_t mreset();
    ms_t z;
    z.pc = 0; z.ins = '0; z.v = 0; z.h = 0; z.cnt = 0;
    return z;
  endfunction

  task automatic model_edge();
    bit base;
    logic [31:0] r0, r1;
    base = (state == 3'd0) && !stall;
    r0 = (s0.pc < 256) ? ref0[s0.pc] : 32'h0;
    r1 = (s1.pc < 6) ? ref1[s1.pc] : 32'h0;
    s0 = mstep(s0, base && !le0 && !rv0, rv0, int'(rpc0),
               int'(pl0), 8, r0);
    s1 = mstep(s1, base && !le1 && !rv1, rv1, int'(rpc1),
               int'(pl1), 3, r1);
    if (le0) ref0[la0] = ld0;
    if (le1 && la1 < 3'd6) ref1[la1] = ld1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc0",  32'(pc0), 32'(s0.pc));
    chk("ins0", ins0,     s0.ins);
    chk("v0",   32'(v0),  32'(s0.v));
    chk("h0",   32'(h0),  32'(s0.h));
    chk("fc0",  32'(fc0), 32'(s0.cnt));
    chk("pc1",  32'(pc1), 32'(s1.pc));
    chk("ins1", ins1,     s1.ins);
    chk("v1",   32'(v1),  32'(s1.v));
    chk("h1",   32'(h1),  32'(s1.h));
    chk("fc1",  32'(fc1), 32'(s1.cnt));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    rv0 = 0; rv1 = 0; le0 = 0; le1 = 0; stall = 0;
  endtask

  initial begin
    rst_n = 0; state = 3'd0; quiet();
    rpc0 = '0; rpc1 = '0; la0 = '0; la1 = '0;
    ld0 = '0; ld1 = '0; pl0 = 9'd7; pl1 = 4'd8;
    s0 = mreset(); s1 = mreset();
    #2;
    check_all();
    repeat (2) cyc();
    @(negedge clk) rst_n = 1;

    // Program load; narrow instance also tries addresses 6 and 7
    for (int k = 0; k < 256; k++) begin
      le0 = 1; la0 = k[7:0];
      ld0 = (k < 7) ? 32'h1000_0000 + k : $urandom;
      le1 = (k < 8); la1 = k[2:0]; ld1 = 32'h2000_0000 + k;
      cyc();
    end
    quiet();

    repeat (8) cyc();
    chk("run_halt", 32'(h0), 32'd1);
    chk("run_pc", 32'(pc0), 32'd7);
    chk("run_cnt", 32'(fc0), 32'd7);

    rv0 = 1; rpc0 = 8'd0; cyc(); rv0 = 0;
    chk("redir_unhalt", 32'(h0), 32'd0);

    repeat (2) cyc();
    stall = 1; repeat (3) cyc();
    chk("stall_pc", 32'(pc0), 32'd2);
    chk("stall_ins", ins0, 32'h1000_0001);
    chk("stall_v", 32'(v0), 32'd0);
    stall = 0; cyc();
    chk("post_stall_ins", ins0, 32'h1000_0002);
    chk("post_stall_pc", 32'(pc0), 32'd3);

    repeat (2) cyc();
    rv0 = 1; rpc0 = 8'd1; cyc(); rv0 = 0;
    chk("redir_pc", 32'(pc0), 32'd1);
    chk("redir_v", 32'(v0), 32'd0);
    cyc();
    chk("redir_ins", ins0, 32'h1000_0001);
    chk("redir_pc2", 32'(pc0), 32'd2);

    for (int i = 0; i < 10; i++) begin
      state = 3'(i % 5);
      cyc();
    end
    state = 3'd0;
    chk("gate_pc", 32'(pc0), 32'd4);

    // Asynchronous reset between edges
    #3 rst_n = 0;
    #1;
    s0 = mreset(); s1 = mreset();
    check_all();
    #1 rst_n = 1;
    cyc();
    chk("rst_mem0", ins0, 32'h1000_0000);

    for (int i = 0; i < 3000; i++) begin
      state = ($urandom_range(0, 9) < 7) ? 3'd0
              : 3'($urandom_range(1, 4));
      stall = ($urandom_range(0, 99) < 15);
      rv0 = ($urandom_range(0, 99) < 5);
      rpc0 = 8'($urandom_range(0, 255));
      rv1 = ($urandom_range(0, 99) < 5);
      rpc1 = 3'($urandom_range(0, 7));
      le0 = ($urandom_range(0, 99) < 10);
      la0 = 8'($urandom_range(0, 255));
      ld0 = $urandom;
      le1 = ($urandom_range(0, 99) < 10);
      la1 = 3'($urandom_range(0, 7));
      ld1 = $urandom;
      if ($urandom_range(0, 99) < 2)
        pl0 = 9'($urandom_range(0, 256));
      if ($urandom_range(0, 99) < 2)
        pl1 = ($urandom_range(0, 1) == 1) ? 4'd8
              : 4'($urandom_range(0, 8));
      cyc();
    end
    quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage, successor to the fixed 7-entry fetch block. It holds a writable instruction memory and walks a program counter while the processor state machine is in the instruction-fetch state. It adds stall, branch/jump redirect, a run-time program length with sticky halt, a fetch-valid pulse and a fetch counter. It sits between the top-level state machine and decode.

Parameters:
PC_WIDTH, 8, program counter width in bits.
IMEM_DEPTH, 256, number of instruction words; must be <= 2**PC_WIDTH.
INSTR_WIDTH, 32, instruction word width.
STATE_WIDTH, 3, width of the processor state bus.
IF_CODE, 0, state encoding of instruction fetch; instantiated with `STATE_IF from state_defs.v.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
state  in  STATE_WIDTH  current processor state.
stall  in  1  holds fetch while high.
redirect_valid  in  1  loads redirect_pc into the PC this cycle.
redirect_pc  in  PC_WIDTH  branch/jump target.
prog_len  in  PC_WIDTH+1  number of valid instructions from address 0.
load_en  in  1  instruction-memory write enable.
load_addr  in  PC_WIDTH  write address.
load_data  in  INSTR_WIDTH  write data.
program_counter  out  PC_WIDTH  address of the next fetch.
instruction  out  INSTR_WIDTH  last fetched instruction.
instr_valid  out  1  one-cycle pulse, high for one cycle after each fetch.
halted  out  1  sticky; high when the PC has run past prog_len.
fetch_count  out  16  total fetches since reset.

Behaviour:
- Reset (rst_n low, asynchronous): program_counter=0, instruction=0, instr_valid=0, halted=0, fetch_count=0. Takes effect immediately, not at the next edge. Memory contents are not cleared.
- Define if_cyc = (state==IF_CODE) && !stall && !load_en && !redirect_valid.
- Each posedge, in priority order:
  1. redirect_valid: PC<=redirect_pc; halted<=0; instr_valid<=0; instruction is held. This applies in any state.
  2. if_cyc && PC < prog_len: instruction<=mem[PC]; PC<=PC+1, wrapping modulo 2**PC_WIDTH; instr_valid<=1; fetch_count<=fetch_count+1, saturating at 16'hFFFF.
  3. if_cyc && PC >= prog_len: halted<=1; instr_valid<=0; PC and instruction are held.
  4. Otherwise: instr_valid<=0; PC and instruction are held.
- Fetch latency: one cycle. The instruction for address A is valid on the edge after the IF cycle at A. instr_valid is never high for two consecutive cycles unless consecutive IF cycles occur.
- Halted state: while halted=1, IF cycles perform no fetch. Only redirect or reset clears halted.
- Out-of-range read: if PC >= IMEM_DEPTH, the fetch returns all-zeros (NOP) and still counts as a fetch.
- Memory write: load_en at posedge writes mem[load_addr]<=load_data. Writes with load_addr >= IMEM_DEPTH are ignored. load_en blocks fetch in the same cycle, so there is no read/write collision. load_en and redirect_valid together: both the write and the PC update take effect.
- stall: overrides IF. PC, instruction, halted and fetch_count are held; instr_valid is 0.
- prog_len==0: the first IF cycle sets halted with no fetch.
- prog_len is sampled every cycle. Changing it mid-run takes effect at the next IF cycle.

Test Plan:
1. Normal run. Reset, then load 7 words at addresses 0..6 (word k=32'h1000_000k), prog_len=7, state=IF every cycle. Required: instruction steps through 0x10000000..0x10000006, program_counter reads 1..7, 7 instr_valid pulses. On the 8th IF cycle halted=1, PC=7, fetch_count=7.
2. Stall. After the 2nd fetch, hold stall high for 3 IF cycles. Required: PC stays 2, instruction=0x10000001, instr_valid=0 throughout. The first IF after release yields 0x10000002 with PC=3.
3. Redirect. At PC=5, raise redirect_valid with redirect_pc=1 together with state=IF. Required: PC=1, no valid pulse, fetch_count unchanged; the next IF fetches 0x10000001 and PC=2. Redirect to 0 while halted: halted drops to 0 and fetching resumes.
4. State gating. Cycle state through IF, ID, EX, MEM, WB repeatedly. Required: exactly one fetch per 5-cycle loop, instr_valid high only on the cycle after IF, PC increments once per loop.
5. Mid-run reset. Drop rst_n between clock edges at PC=4. Required: all outputs read 0 before the next edge. After release, the first IF fetches the retained mem[0]=0x10000000.
6. Wrap and range. Configure PC_WIDTH=3, IMEM_DEPTH=6, prog_len=8, with a load to address 6 (which is ignored). Required: PCs 6 and 7 return 0 with valid pulses, PC wraps 7->0, and fetching continues without halting.
